// File: rtl/seg7_to_ascii_uart_tx_if.sv
// seg7_to_ascii_uart_tx_if: valid/ready handshake carrying an active-low 7-segment pattern
// seg_in    : active-low segment pattern {g,f,e,d,c,b,a}, driven by the source
// seg_valid : source has a pattern to send
// seg_ready : sink can accept a pattern this cycle
interface seg7_to_ascii_uart_tx_if;
  logic [6:0] seg_in;
  logic seg_valid;
  logic seg_ready;
  modport master(output seg_in, output seg_valid, input seg_ready);
  modport slave(input seg_in, input seg_valid, output seg_ready);
endinterface

// File: rtl/seg7_to_ascii_uart_tx.sv
// seg7_to_ascii_uart_tx: encode a 7-segment pattern to ASCII and send it as one UART frame
// clk, rst    : system clock, asynchronous active-high reset
// s           : slave side of the segment-pattern valid/ready handshake
// tx          : UART serial line, idle high, 8N1 (8E1 when SEG_TX_PARITY_EN is defined)
// busy        : frame in progress
// ascii_out   : ASCII code of the pattern currently or last transmitted
// invalid_seg : one-cycle pulse when an accepted pattern has no encoding (sent as '?')
module seg7_to_ascii_uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic clk,
  input  logic rst,
  seg7_to_ascii_uart_tx_if.slave s,
  output logic tx,
  output logic busy,
  output logic [7:0] ascii_out,
  output logic invalid_seg
);
`ifdef SEG_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif
  state_t state, state_n;
  logic [15:0] clk_cnt, cnt_n;
  logic [2:0] bit_idx, idx_n;
  logic [7:0] enc;
  logic tx_n, fire, last;
  assign s.seg_ready = state == IDLE;
  assign busy = state != IDLE;
  assign fire = s.seg_valid && s.seg_ready;
  assign last = clk_cnt == 16'(CLKS_PER_BIT - 1);
  always_comb begin
    case (s.seg_in)
      7'b1000000: enc = 8'h30;
      7'b1111001: enc = 8'h31;
      7'b0100100: enc = 8'h32;
      7'b0110000: enc = 8'h33;
      7'b0011001: enc = 8'h34;
      7'b0010010: enc = 8'h35;
      7'b0000010: enc = 8'h36;
      7'b1111000: enc = 8'h37;
      7'b0000000: enc = 8'h38;
      7'b0010000: enc = 8'h39;
      7'b0001000: enc = 8'h41;
      7'b0000011: enc = 8'h42;
      7'b1000110: enc = 8'h43;
      7'b0100001: enc = 8'h44;
      7'b0000110: enc = 8'h45;
      7'b0001110: enc = 8'h46;
      7'b1111111: enc = 8'h20;
      default:    enc = 8'h3F;
    endcase
  end
  // tx_n is the line level for the current state; registering it puts tx one cycle behind state
  always_comb begin
    state_n = state;
    idx_n = bit_idx;
    cnt_n = (state == IDLE || last) ? 16'd0 : clk_cnt + 16'd1;
    tx_n = 1'b1;
    case (state)
      IDLE: state_n = fire ? START : IDLE;
      START: begin
        tx_n = 1'b0;
        if (last) begin
          state_n = DATA;
          idx_n = 3'd0;
        end
      end
      DATA: begin
        tx_n = ascii_out[bit_idx];
        if (last) begin
          idx_n = bit_idx + 3'd1;
`ifdef SEG_TX_PARITY_EN
          if (bit_idx == 3'd7) state_n = PARITY;
`else
          if (bit_idx == 3'd7) state_n = STOP;
`endif
        end
      end
`ifdef SEG_TX_PARITY_EN
      PARITY: begin
        tx_n = ^ascii_out;
        if (last) state_n = STOP;
      end
`endif
      STOP: state_n = last ? IDLE : STOP;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      clk_cnt <= 16'd0;
      bit_idx <= 3'd0;
      tx <= 1'b1;
      ascii_out <= 8'h00;
      invalid_seg <= 1'b0;
    end else begin
      state <= state_n;
      clk_cnt <= cnt_n;
      bit_idx <= idx_n;
      tx <= tx_n;
      ascii_out <= fire ? enc : ascii_out;
      invalid_seg <= fire && enc == 8'h3F;
    end
  end
endmodule

// File: doc/seg7_to_ascii_uart_tx.md
Name: seg7_to_ascii_uart_tx

Overview:
Inverse path of the board's ASCII-to-7-segment display decode. Accepts an active-low 7-segment pattern (bit 6 = g … bit 0 = a, 0 = segment lit) over a valid/ready handshake. Encodes the pattern back to its ASCII character and transmits it as one UART 8N1 frame. Sits between the segment-pattern source (switches or captured display state) and the board's serial TX pin.

Parameters:
CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous active-high reset
seg_in  input  7  active-low segment pattern {g,f,e,d,c,b,a}
seg_valid  input  1  seg_in holds a pattern to send
seg_ready  output  1  block can accept a pattern this cycle
tx  output  1  UART serial line, idle high
busy  output  1  frame in progress
ascii_out  output  8  ASCII code of the pattern currently or last transmitted
invalid_seg  output  1  one-cycle pulse: accepted pattern had no encoding

Behaviour:
- Reset values: tx=1, busy=0, seg_ready=1, ascii_out=8'h00, invalid_seg=0, state=IDLE, counters=0.
- Encode table (seg_in -> ASCII):
  - Digits: 1000000->30, 1111001->31, 0100100->32, 0110000->33, 0011001->34, 0010010->35, 0000010->36, 1111000->37, 0000000->38, 0010000->39.
  - Letters: 0001000->41, 0000011->42, 1000110->43, 0100001->44, 0000110->45, 0001110->46.
  - Blank: 1111111->20 (space), not flagged invalid.
  - Any other pattern: send 3F ('?') and pulse invalid_seg.
- Handshake:
  - seg_ready = (state==IDLE); it is combinational from the registered state.
  - Transfer occurs on the rising edge where seg_valid && seg_ready.
  - On that edge: ascii_out is loaded with the encoded value; invalid_seg is set for exactly one cycle if the pattern was unmatched; state goes to START.
  - seg_valid while not ready is ignored; no queueing.
- FSM (bit counter clk_cnt counts 0..CLKS_PER_BIT-1):
  - IDLE: tx=1, busy=0. Moves to START on transfer.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=ascii_out[bit_idx], LSB first; each bit held CLKS_PER_BIT cycles; after bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE.
- tx, busy and seg_ready are driven from registers (tx registered, glitch-free).
- Latency: tx falls on the first rising edge after the transfer edge. A full frame is 10*CLKS_PER_BIT cycles. seg_ready rises the cycle after the final stop-bit cycle.
- Back-to-back: if seg_valid is held high, the next transfer occurs in the first IDLE cycle, giving exactly one idle-high cycle between frames.
- ascii_out stays stable from the transfer until the next transfer.
- Reset mid-frame: the frame is aborted immediately (asynchronously), tx=1, all outputs return to reset values; no partial stop bit is generated.
- seg_in is sampled only at the transfer edge; later changes do not affect the frame in flight.

Optional Feature:
SEG_TX_PARITY_EN
- Defined: a PARITY state is inserted between DATA and STOP, driving the even-parity bit (^ascii_out) for CLKS_PER_BIT cycles. Frame length becomes 11*CLKS_PER_BIT.
- Undefined: no PARITY state; frame is 8N1, 10*CLKS_PER_BIT cycles.

Test Plan:
- CLKS_PER_BIT=4, reset then idle 10 cycles -> tx=1, seg_ready=1, busy=0, ascii_out=00.
- seg_in=7'b0100100 pulsed valid one cycle -> ascii_out=32; tx sequence 0,0,1,0,0,1,1,0,0,1, each held 4 cycles; total 40 cycles; invalid_seg stays 0.
- seg_in=7'b1010101 -> ascii_out=3F, invalid_seg high exactly one cycle, frame carries 3F; seg_in=7'b1111111 -> 20, no invalid pulse.
- seg_valid held high with 0001000 then 0000110 -> two frames (41, 45), exactly one idle-high cycle between them; a seg_valid pulse mid-frame is ignored.
- Assert rst during DATA bit 3 -> tx=1 and busy=0 without waiting for a clock edge; after release, a new pattern 1111001 sends 31 correctly.
- With SEG_TX_PARITY_EN defined, send 0000000 (38, three ones) -> parity bit 1 before stop; frame is 44 cycles.
